// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared codes, state type and width helper for the CIC decimator
package dsm_pkg;

  // Ternary pwm line codes
  localparam logic [1:0] DSM_POS  = 2'b01;
  localparam logic [1:0] DSM_NEG  = 2'b11;
  localparam logic [1:0] DSM_ZERO = 2'b00;
  localparam logic [1:0] DSM_INV  = 2'b10;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } dsm_state_e;

  // Accumulator width that holds the full CIC gain R^N for a +/-1 input
  function automatic int acc_width(input int n_order, input int dec_log2);
    return 2 + n_order * dec_log2;
  endfunction

endpackage

// File: rtl/dsm_cic_core.sv
// rtl/dsm_cic_core.sv - CIC integrators, decimation counter and comb chain
module dsm_cic_core
  import dsm_pkg::*;
#(
  parameter int N_ORDER  = 3,
  parameter int DEC_LOG2 = 4,
  parameter int ACC_W    = acc_width(N_ORDER, DEC_LOG2)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sample_valid_i,
  input  logic signed [ACC_W-1:0] sample_i,
  output logic                    tick_o,
  output logic signed [ACC_W-1:0] comb_o
);

  logic [DEC_LOG2-1:0]     cnt_q;
  logic                    tick;
  logic signed [ACC_W-1:0] stage0_q;
  logic                    stage0_vld_q;
  logic signed [ACC_W-1:0] comb_q;
  logic                    comb_vld_q;

  // Integrator cascade: each stage adds the freshly updated value of the stage
  // before it, so the tick snapshot includes the tick sample in every stage.
  for (genvar k = 0; k < N_ORDER; k++) begin : g_int
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    if (k == 0) begin : g_first
      assign acc_d = acc_q + sample_i;
    end else begin : g_next
      assign acc_d = acc_q + g_int[k-1].acc_d;
    end

    // Wrap-around accumulation, advanced only on valid input samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        acc_q <= '0;
      end else if (sample_valid_i) begin
        acc_q <= acc_d;
      end
    end
  end

  assign tick = sample_valid_i && (cnt_q == '1);

  // Decimation counter over valid samples; wraps naturally at R
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (sample_valid_i) begin
      cnt_q <= cnt_q + DEC_LOG2'(1);
    end
  end

  // Snapshot the last integrator into the low-rate comb pipeline on each tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage0_q     <= '0;
      stage0_vld_q <= 1'b0;
    end else begin
      stage0_vld_q <= tick;
      if (tick) begin
        stage0_q <= g_int[N_ORDER-1].acc_d;
      end
    end
  end

  // Comb chain: y = x - x_prev, history advanced once per tick
  for (genvar k = 0; k < N_ORDER; k++) begin : g_comb
    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] y;
    logic signed [ACC_W-1:0] prev_q;

    if (k == 0) begin : g_first
      assign x = stage0_q;
    end else begin : g_next
      assign x = g_comb[k-1].y;
    end

    assign y = x - prev_q;

    // Remember this stage's input for the next tick's difference
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q <= '0;
      end else if (stage0_vld_q) begin
        prev_q <= x;
      end
    end
  end

  // Register the comb result one clock after the stage-0 snapshot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      comb_q     <= '0;
      comb_vld_q <= 1'b0;
    end else begin
      comb_vld_q <= stage0_vld_q;
      if (stage0_vld_q) begin
        comb_q <= g_comb[N_ORDER-1].y;
      end
    end
  end

  assign tick_o = comb_vld_q;
  assign comb_o = comb_q;

endmodule

// File: rtl/dsm_decimator.sv
// rtl/dsm_decimator.sv - ternary pwm stream to signed samples via CIC decimation
module dsm_decimator
  import dsm_pkg::*;
#(
  parameter int N_ORDER  = 3,
  parameter int DEC_LOG2 = 4,
  parameter int OUT_W    = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pwm_valid,
  input  logic [1:0]              pwm,
  output logic signed [OUT_W-1:0] vout,
  output logic                    vout_valid,
  output logic                    code_err
);

  localparam int ACC_W = acc_width(N_ORDER, DEC_LOG2);
  localparam int SHIFT = N_ORDER * DEC_LOG2 - (OUT_W - 1);
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;
  localparam logic [2:0] FILL_LAST = 3'(N_ORDER - 1);

  logic signed [ACC_W-1:0] sample_d;
  logic                    comb_vld;
  logic signed [ACC_W-1:0] comb_raw;
  logic signed [ACC_W-1:0] scaled;
  logic signed [OUT_W-1:0] sat_d;

  dsm_state_e              state_q;
  logic [2:0]              fill_cnt_q;
  logic signed [OUT_W-1:0] vout_q;
  logic                    vout_valid_q;
  logic                    code_err_q;

  // Map the line code to +1/-1/0; the invalid code contributes nothing
  always_comb begin
    sample_d = '0;
    case (pwm)
      DSM_POS: sample_d = ACC_W'(1);
      DSM_NEG: sample_d = '1;
      default: sample_d = '0;
    endcase
  end

  dsm_cic_core #(
    .N_ORDER  (N_ORDER),
    .DEC_LOG2 (DEC_LOG2),
    .ACC_W    (ACC_W)
  ) u_core (
    .clk_i          (clock),
    .rst_ni         (reset),
    .sample_valid_i (pwm_valid),
    .sample_i       (sample_d),
    .tick_o         (comb_vld),
    .comb_o         (comb_raw)
  );

  assign scaled = comb_raw >>> SHIFT;

  // Clamp the scaled comb value into the signed output range
  always_comb begin
    sat_d = scaled[OUT_W-1:0];
    if (scaled > Q_MAX) begin
      sat_d = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (scaled < Q_MIN) begin
      sat_d = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  // FILL discards the first N_ORDER comb results; RUN strobes every one after
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= FILL;
      fill_cnt_q   <= '0;
      vout_q       <= '0;
      vout_valid_q <= 1'b0;
    end else begin
      vout_valid_q <= 1'b0;
      if (comb_vld) begin
        case (state_q)
          FILL: begin
            if (fill_cnt_q == FILL_LAST) begin
              state_q <= RUN;
            end else begin
              fill_cnt_q <= fill_cnt_q + 3'd1;
            end
          end
          RUN: begin
            vout_q       <= sat_d;
            vout_valid_q <= 1'b1;
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  // Sticky flag for any invalid code seen on a qualified cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      code_err_q <= 1'b0;
    end else if (pwm_valid && (pwm == DSM_INV)) begin
      code_err_q <= 1'b1;
    end
  end

  assign vout       = vout_q;
  assign vout_valid = vout_valid_q;
  assign code_err   = code_err_q;

endmodule

// File: tb/tb_dsm_decimator.sv
// tb/tb_dsm_decimator.sv - directed self-checking bench for dsm_decimator
module tb_dsm_decimator;

  logic              clock;
  logic              reset;
  logic              pwm_valid;
  logic [1:0]        pwm;
  logic signed [7:0] vout;
  logic              vout_valid;
  logic              code_err;

  int n_checks;
  int n_fail;
  int step_cnt;
  logic signed [7:0] sv_q[$];
  int                ss_q[$];

  dsm_decimator dut (
    .clock      (clock),
    .reset      (reset),
    .pwm_valid  (pwm_valid),
    .pwm        (pwm),
    .vout       (vout),
    .vout_valid (vout_valid),
    .code_err   (code_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock with the given inputs; records any strobe seen after the edge
  task automatic drive(input logic v, input logic [1:0] c);
    pwm_valid = v;
    pwm       = c;
    @(posedge clock);
    #1;
    step_cnt++;
    if (vout_valid === 1'b1) begin
      sv_q.push_back(vout);
      ss_q.push_back(step_cnt);
    end
  endtask

  task automatic do_reset();
    pwm_valid = 1'b0;
    pwm       = 2'b00;
    reset     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset    = 1'b1;
    step_cnt = 0;
    sv_q.delete();
    ss_q.delete();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    pwm_valid = 1'b0;
    pwm       = 2'b00;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (vout !== 8'sd0) begin
      $display("FAIL reset_vout: got %0d expected 0", vout); n_fail++;
    end
    n_checks++;
    if (vout_valid !== 1'b0) begin
      $display("FAIL reset_vout_valid: got %b expected 0", vout_valid); n_fail++;
    end
    n_checks++;
    if (code_err !== 1'b0) begin
      $display("FAIL reset_code_err: got %b expected 0", code_err); n_fail++;
    end
    do_reset();
  endtask

  task automatic test_const_pos();
    do_reset();
    for (int s = 0; s < 146; s++) drive(1'b1, 2'b01);
    n_checks++;
    if (ss_q.size() != 6) begin
      $display("FAIL pos_strobe_count: got %0d expected 6", ss_q.size()); n_fail++;
    end
    n_checks++;
    if (ss_q.size() == 0 || ss_q[0] != 66) begin
      $display("FAIL pos_first_strobe: got %0d expected 66", ss_q.size() == 0 ? -1 : ss_q[0]); n_fail++;
    end
    for (int i = 1; i < ss_q.size(); i++) begin
      n_checks++;
      if (ss_q[i] - ss_q[i-1] != 16) begin
        $display("FAIL pos_spacing[%0d]: got %0d expected 16", i, ss_q[i] - ss_q[i-1]); n_fail++;
      end
    end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== 8'sd127) begin
        $display("FAIL pos_value[%0d]: got %0d expected 127", i, sv_q[i]); n_fail++;
      end
    end
    n_checks++;
    if (code_err !== 1'b0) begin
      $display("FAIL pos_code_err: got %b expected 0", code_err); n_fail++;
    end
  endtask

  task automatic test_const_neg_zero();
    logic signed [7:0] neg_full;
    neg_full = -8'sd128;
    do_reset();
    for (int s = 0; s < 98; s++) drive(1'b1, 2'b11);
    n_checks++;
    if (sv_q.size() != 3) begin
      $display("FAIL neg_strobe_count: got %0d expected 3", sv_q.size()); n_fail++;
    end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== neg_full) begin
        $display("FAIL neg_value[%0d]: got %0d expected -128", i, sv_q[i]); n_fail++;
      end
    end
    do_reset();
    for (int s = 0; s < 98; s++) drive(1'b1, 2'b00);
    n_checks++;
    if (sv_q.size() != 3) begin
      $display("FAIL zero_strobe_count: got %0d expected 3", sv_q.size()); n_fail++;
    end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== 8'sd0) begin
        $display("FAIL zero_value[%0d]: got %0d expected 0", i, sv_q[i]); n_fail++;
      end
    end
    n_checks++;
    if (code_err !== 1'b0) begin
      $display("FAIL negzero_code_err: got %b expected 0", code_err); n_fail++;
    end
  endtask

  task automatic test_patterns();
    logic [1:0] pat3 [4];
    pat3 = '{2'b01, 2'b01, 2'b01, 2'b00};
    do_reset();
    for (int s = 0; s < 98; s++) drive(1'b1, pat3[s % 4]);
    n_checks++;
    if (sv_q.size() != 3) begin
      $display("FAIL p3of4_strobe_count: got %0d expected 3", sv_q.size()); n_fail++;
    end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== 8'sd96) begin
        $display("FAIL p3of4_value[%0d]: got %0d expected 96", i, sv_q[i]); n_fail++;
      end
    end
    do_reset();
    for (int s = 0; s < 98; s++) drive(1'b1, (s % 2 == 0) ? 2'b01 : 2'b11);
    n_checks++;
    if (sv_q.size() != 3) begin
      $display("FAIL alt_strobe_count: got %0d expected 3", sv_q.size()); n_fail++;
    end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== 8'sd0) begin
        $display("FAIL alt_value[%0d]: got %0d expected 0", i, sv_q[i]); n_fail++;
      end
    end
  endtask

  // Invalid code lands on the tick sample of the 6th tick (step 96); the three
  // following outputs lose 1, 150 and 105 counts of 4096 respectively.
  task automatic test_invalid_code();
    int exp_v [6];
    exp_v = '{127, 127, 127, 123, 124, 127};
    do_reset();
    for (int s = 1; s <= 146; s++) begin
      drive(1'b1, (s == 96) ? 2'b10 : 2'b01);
      if (s == 95) begin
        n_checks++;
        if (code_err !== 1'b0) begin
          $display("FAIL inv_code_err_before: got %b expected 0", code_err); n_fail++;
        end
      end
      if (s == 96) begin
        n_checks++;
        if (code_err !== 1'b1) begin
          $display("FAIL inv_code_err_set: got %b expected 1", code_err); n_fail++;
        end
      end
    end
    n_checks++;
    if (sv_q.size() != 6) begin
      $display("FAIL inv_strobe_count: got %0d expected 6", sv_q.size()); n_fail++;
    end
    for (int i = 0; i < sv_q.size() && i < 6; i++) begin
      n_checks++;
      if (sv_q[i] !== 8'(exp_v[i])) begin
        $display("FAIL inv_value[%0d]: got %0d expected %0d", i, sv_q[i], exp_v[i]); n_fail++;
      end
    end
    n_checks++;
    if (code_err !== 1'b1) begin
      $display("FAIL inv_code_err_sticky: got %b expected 1", code_err); n_fail++;
    end
  endtask

  // Random idle cycles carry the invalid code, which must be ignored
  task automatic test_gaps();
    logic [1:0] pat3 [4];
    int nvalid;
    int guard;
    pat3 = '{2'b01, 2'b01, 2'b01, 2'b00};
    do_reset();
    nvalid = 0;
    guard  = 0;
    while (nvalid < 144 && guard < 2000) begin
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, pat3[nvalid % 4]);
        nvalid++;
      end else begin
        drive(1'b0, 2'b10);
      end
      guard++;
    end
    n_checks++;
    if (nvalid != 144) begin
      $display("FAIL gap_budget: got %0d valid inputs expected 144", nvalid); n_fail++;
    end
    drive(1'b0, 2'b00);
    drive(1'b0, 2'b00);
    n_checks++;
    if (sv_q.size() != 6) begin
      $display("FAIL gap_strobe_count: got %0d expected 6", sv_q.size()); n_fail++;
    end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== 8'sd96) begin
        $display("FAIL gap_value[%0d]: got %0d expected 96", i, sv_q[i]); n_fail++;
      end
    end
    n_checks++;
    if (ss_q.size() < 6 || (ss_q[5] - ss_q[0]) < 100 || (ss_q[5] - ss_q[0]) > 220) begin
      $display("FAIL gap_span: got %0d clocks over 5 intervals expected about 160",
               ss_q.size() < 6 ? -1 : ss_q[5] - ss_q[0]);
      n_fail++;
    end
    n_checks++;
    if (code_err !== 1'b0) begin
      $display("FAIL gap_code_err: got %b expected 0", code_err); n_fail++;
    end
  endtask

  // Reset drops in the cycle before a strobe is due (step 114)
  task automatic test_reset_mid_run();
    do_reset();
    for (int s = 1; s <= 113; s++) drive(1'b1, (s == 90) ? 2'b10 : 2'b01);
    n_checks++;
    if (code_err !== 1'b1 || vout !== 8'sd127) begin
      $display("FAIL mid_pre_state: got code_err=%b vout=%0d expected 1 and 127", code_err, vout); n_fail++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (vout !== 8'sd0 || vout_valid !== 1'b0 || code_err !== 1'b0) begin
      $display("FAIL mid_async_clear: got vout=%0d valid=%b err=%b expected 0 0 0",
               vout, vout_valid, code_err);
      n_fail++;
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if (vout_valid !== 1'b0 || vout !== 8'sd0) begin
        $display("FAIL mid_hold[%0d]: got valid=%b vout=%0d expected 0 0", c, vout_valid, vout); n_fail++;
      end
    end
    reset    = 1'b1;
    step_cnt = 0;
    sv_q.delete();
    ss_q.delete();
    for (int s = 0; s < 98; s++) drive(1'b1, 2'b01);
    n_checks++;
    if (ss_q.size() != 3 || ss_q[0] != 66) begin
      $display("FAIL mid_refill: got %0d strobes first at %0d expected 3 first at 66",
               ss_q.size(), ss_q.size() == 0 ? -1 : ss_q[0]);
      n_fail++;
    end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== 8'sd127) begin
        $display("FAIL mid_value[%0d]: got %0d expected 127", i, sv_q[i]); n_fail++;
      end
    end
    n_checks++;
    if (code_err !== 1'b0) begin
      $display("FAIL mid_code_err: got %b expected 0", code_err); n_fail++;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    step_cnt  = 0;
    reset     = 1'b1;
    pwm_valid = 1'b0;
    pwm       = 2'b00;
    test_reset();
    test_const_pos();
    test_const_neg_zero();
    test_patterns();
    test_invalid_code();
    test_gaps();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
